slicer_4_ask_ref_est: RTL and testbench

SLICER_4_ASK_REF_EST -- requirements
Module: slicer_4_ask_ref_est

---
 rtl/slicer_4_ask_ref_est_if.sv | 24 ++
 rtl/slicer_4_ask_ref_est.sv | 137 +++++++++++++
 tb/tb_slicer_4_ask_ref_est.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/slicer_4_ask_ref_est_if.sv
// Bundle of the slicer's sample input and decision/estimate outputs.
// The source of samples uses the master modport; the slicer uses the slave modport.
// Handshake: there is no back-pressure. A sample is accepted on every rising clk
// edge where clk_en is high, and outputs change only on such edges (or on reset).
// state_dbg mirrors the estimator FSM (0 = ACQUIRE, 1 = TRACK) for observation.
interface slicer_4_ask_ref_est_if;
    logic               clk_en;
    logic signed [17:0] in_sig;
    logic        [1:0]  data_out;
    logic signed [17:0] err;
    logic signed [17:0] ref_level;
    logic               ref_valid;
    logic               state_dbg;

    modport master (
        output clk_en, in_sig,
        input  data_out, err, ref_level, ref_valid, state_dbg
    );

    modport slave (
        input  clk_en, in_sig,
        output data_out, err, ref_level, ref_valid, state_dbg
    );
endinterface

// File: rtl/slicer_4_ask_ref_est.sv
// 4-ASK slicer with a block-average reference-level estimator.
// Each accepted sample is sliced into a Gray-coded decision against the
// current ref_level, and |in_sig| is summed over windows of 2^LOG2_LEN
// samples. The window mean becomes the new ref_level.
// Optional feature: define SLICER_ERR_EN to build the saturated slicer
// error output; without it err is constant zero.
module slicer_4_ask_ref_est #(
    parameter int                 LOG2_LEN = 8,
    parameter logic signed [17:0] REF_INIT = 18'sd32768
) (
    input  logic                  clk,
    input  logic                  reset,
    slicer_4_ask_ref_est_if.slave bus
);
    localparam int ACC_W = 18 + LOG2_LEN;

    typedef enum logic {ACQUIRE = 1'b0, TRACK = 1'b1} state_t;

    state_t                 state, state_nxt;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       acc_sum;
    logic [LOG2_LEN-1:0]    cnt;
    logic [17:0]            abs_x;
    logic signed [18:0]     in19, ref19, neg_ref19;
    logic [1:0]             dec;
    logic [1:0]             data_q;
    logic signed [17:0]     ref_q;
    logic                   valid_q;
    logic                   window_end;

    assign in19       = {bus.in_sig[17], bus.in_sig};
    assign ref19      = {ref_q[17], ref_q};
    assign neg_ref19  = -ref19;
    assign acc_sum    = acc + {{LOG2_LEN{1'b0}}, abs_x};
    assign window_end = bus.clk_en && (cnt == '1);

    // Magnitude of the sample; the most negative code clips to the largest positive.
    always_comb begin
        abs_x = bus.in_sig;
        if (bus.in_sig == {1'b1, 17'd0})
            abs_x = 18'h1FFFF;
        else if (bus.in_sig[17])
            abs_x = -bus.in_sig;
    end

    // Threshold slicing: 0 and +ref round up, -ref rounds to the outer level.
    always_comb begin
        dec = 2'b10;
        if (in19 >= ref19)
            dec = 2'b01;
        else if (in19 >= 19'sd0)
            dec = 2'b00;
        else if (in19 > neg_ref19)
            dec = 2'b11;
    end

`ifdef SLICER_ERR_EN
    logic signed [17:0] half18, outer18, err_sat, err_q;
    logic signed [18:0] half19, outer19, level19, diff19;

    assign half18  = {1'b0, ref_q[17:1]};
    assign outer18 = ref_q + half18;
    assign half19  = {half18[17], half18};
    assign outer19 = {outer18[17], outer18};

    // Reconstruct the decided level and clip the difference to 18 bits.
    always_comb begin
        level19 = -outer19;
        unique case (dec)
            2'b00:   level19 = half19;
            2'b01:   level19 = outer19;
            2'b11:   level19 = -half19;
            default: level19 = -outer19;
        endcase
        diff19  = in19 - level19;
        err_sat = diff19[17:0];
        if (diff19 > 19'sd131071)
            err_sat = 18'h1FFFF;
        else if (diff19 < -19'sd131072)
            err_sat = {1'b1, 17'd0};
    end

    // Error register, updated with the decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= '0;
        else if (bus.clk_en)
            err_q <= err_sat;
    end

    assign bus.err = err_q;
`else
    assign bus.err = '0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ACQUIRE;
        else
            state <= state_nxt;
    end

    // FSM next state: the first completed window moves to TRACK for good.
    always_comb begin
        state_nxt = state;
        if (window_end)
            state_nxt = TRACK;
    end

    // Decision, accumulator, counter and reference estimate registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= 2'b00;
            acc     <= '0;
            cnt     <= '0;
            ref_q   <= REF_INIT;
            valid_q <= 1'b0;
        end else if (bus.clk_en) begin
            data_q <= dec;
            if (window_end) begin
                ref_q   <= acc_sum[ACC_W-1:LOG2_LEN];
                acc     <= '0;
                cnt     <= '0;
                valid_q <= 1'b1;
            end else begin
                acc <= acc_sum;
                cnt <= cnt + LOG2_LEN'(1);
            end
        end
    end

    assign bus.data_out  = data_q;
    assign bus.ref_level = ref_q;
    assign bus.ref_valid = valid_q;
    assign bus.state_dbg = (state == TRACK);
endmodule

// File: tb/tb_slicer_4_ask_ref_est.sv
// Bench for slicer_4_ask_ref_est: table-driven threshold vectors, a shuffled
// equiprobable estimation window, random stream with idle gaps, reset checks
// and saturation sequences, all checked against a behavioural model.
`timescale 1ns/1ps
module tb_slicer_4_ask_ref_est;
    localparam int LOG2_LEN = 8;
    localparam int WIN      = 1 << LOG2_LEN;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    slicer_4_ask_ref_est_if bus();

    slicer_4_ask_ref_est #(.LOG2_LEN(LOG2_LEN), .REF_INIT(18'sd32768)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Model state.
    int         m_ref, m_valid, m_cnt, m_err;
    longint     m_sum;
    logic [1:0] m_dout;
    logic [1:0] exp_q[$];

    typedef struct {
        int         x;
        logic [1:0] d;
        int         e;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int abs_sat(input int x);
        if (x == -131072) return 131071;
        return (x < 0) ? -x : x;
    endfunction

    function automatic logic [1:0] decide(input int x, input int r);
        if (x >= r) return 2'b01;
        if (x >= 0) return 2'b00;
        if (x > -r) return 2'b11;
        return 2'b10;
    endfunction

    function automatic int err_of(input int x, input int r, input logic [1:0] d);
        int half, outer, lvl, e;
        half  = (r & 32'h3FFFF) >> 1;
        outer = r + half;
        if (outer > 131071)  outer -= 262144;
        if (outer < -131072) outer += 262144;
        case (d)
            2'b00:   lvl = half;
            2'b01:   lvl = outer;
            2'b11:   lvl = -half;
            default: lvl = -outer;
        endcase
        e = x - lvl;
        if (e > 131071)  e = 131071;
        if (e < -131072) e = -131072;
        return e;
    endfunction

    task automatic model_reset();
        m_ref = 32768; m_valid = 0; m_cnt = 0; m_sum = 0;
        m_dout = 2'b00; m_err = 0;
        exp_q.delete();
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data_out"}, bus.data_out, m_dout);
`ifdef SLICER_ERR_EN
        chk({tag, ".err"}, bus.err, m_err);
`else
        chk({tag, ".err"}, bus.err, 0);
`endif
        chk({tag, ".ref_level"}, bus.ref_level, m_ref);
        chk({tag, ".ref_valid"}, bus.ref_valid, m_valid);
        chk({tag, ".state_dbg"}, bus.state_dbg, m_valid);
    endtask

    // Driver: one accepted sample, model update, outputs checked #1 after the edge.
    task automatic send(input int x, input string tag);
        logic [1:0] d;
        @(negedge clk);
        bus.clk_en = 1'b1;
        bus.in_sig = 18'(x);
        d = decide(x, m_ref);
        exp_q.push_back(d);
        m_err = err_of(x, m_ref, d);
        m_sum += abs_sat(x);
        m_cnt++;
        if (m_cnt == WIN) begin
            m_ref   = int'(m_sum >> LOG2_LEN);
            m_valid = 1;
            m_sum   = 0;
            m_cnt   = 0;
        end
        @(posedge clk);
        #1;
        bus.clk_en = 1'b0;
        m_dout = exp_q.pop_front();
        check_all(tag);
    endtask

    // Driver: clk_en low with garbage on in_sig; nothing may move.
    task automatic idle(input int n);
        @(negedge clk);
        bus.clk_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.in_sig = 18'($urandom);
            @(posedge clk);
            #1;
            check_all("idle");
        end
    endtask

    // Asynchronous reset, checked between clock edges, then released.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(2);
    endtask

    int sym[WIN];

    initial begin
        bus.clk_en = 1'b0;
        bus.in_sig = '0;
        model_reset();
        vecs[0] = '{0,       2'b00, -16384};
        vecs[1] = '{32767,   2'b00,  16383};
        vecs[2] = '{32768,   2'b01, -16384};
        vecs[3] = '{-1,      2'b11,  16383};
        vecs[4] = '{-32767,  2'b11, -16383};
        vecs[5] = '{-32768,  2'b10,  16384};
        vecs[6] = '{50000,   2'b01,    848};

        // Reset and release.
        #12;
        check_all("por");
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Threshold and error table at ref_level = 32768.
        foreach (vecs[i]) begin
            send(vecs[i].x, "tbl");
            chk("tbl.dec", bus.data_out, vecs[i].d);
`ifdef SLICER_ERR_EN
            chk("tbl.err", bus.err, vecs[i].e);
`endif
        end

        // Mid-stream reset, then one window of equiprobable +-20000/+-60000.
        async_reset("rst_mid");
        for (int i = 0; i < WIN; i++) begin
            case (i % 4)
                0: sym[i] = 20000;
                1: sym[i] = -20000;
                2: sym[i] = 60000;
                default: sym[i] = -60000;
            endcase
        end
        for (int i = WIN - 1; i > 0; i--) begin
            int j, t;
            j = $urandom_range(i, 0);
            t = sym[i]; sym[i] = sym[j]; sym[j] = t;
        end
        for (int i = 0; i < WIN - 1; i++) send(sym[i], "est");
        chk("est.ref_before", bus.ref_level, 32768);
        chk("est.valid_before", bus.ref_valid, 0);
        send(sym[WIN-1], "est");
        chk("est.ref_after", bus.ref_level, 40000);
        chk("est.valid_after", bus.ref_valid, 1);
        chk("est.last_dec_old_ref", bus.data_out, decide(sym[WIN-1], 32768));

        // Random stream with idle stretches.
        for (int i = 0; i < 600; i++) begin
            int x;
            x = int'($signed(18'($urandom)));
            if ($urandom_range(3, 0) == 0) x = -131072 + int'($urandom_range(1, 0));
            send(x, "rnd");
            if ($urandom_range(4, 0) == 0) idle($urandom_range(3, 1));
        end

        // Reset at sample 100 of a window; estimate must use only fresh samples.
        async_reset("rst_w0");
        for (int i = 0; i < 100; i++) send(int'($signed(18'($urandom))), "pre");
        async_reset("rst_w100");
        for (int i = 0; i < WIN - 1; i++) send(10000, "fresh");
        chk("fresh.ref_hold", bus.ref_level, 32768);
        chk("fresh.valid_hold", bus.ref_valid, 0);
        send(-10000, "fresh");
        chk("fresh.ref_new", bus.ref_level, 10000);
        chk("fresh.valid_new", bus.ref_valid, 1);

        // Saturation: -131072 accumulates as 131071; error clips at -131072.
        async_reset("rst_sat");
        for (int i = 0; i < WIN; i++) send(-131072, "sat_win");
        chk("sat.ref", bus.ref_level, 131071);
        send(-131072, "sat");
        chk("sat.dec", bus.data_out, 2'b10);
`ifdef SLICER_ERR_EN
        chk("sat.err", bus.err, -131072);
`endif
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
